reset_sequencer: RTL and testbench

Staged reset controller for the arcade core's clock/reset resource. It waits for the clock generator's lock indication, holds every domain in reset for a fixed interval, then releases memory, video and CPU resets in sequence. A debounced front-panel button restarts the sequence and holds the core in reset for the duration of the press. It sits beside the clock generator and drives the active-high reset inputs of the memory, video and CPU subsystems.

---
 rtl/rstseq_pkg.sv | 15 +
 rtl/button_debounce.sv | 41 ++++
 rtl/reset_sequencer.sv | 91 +++++++++
 tb/tb_reset_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rstseq_pkg.sv
// Shared types and defaults for the staged reset sequencer.
package rstseq_pkg;
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    MEM       = 3'd2,
    VID       = 3'd3,
    RUN       = 3'd4
  } state_e;

  localparam int CNT_W               = 16;
  localparam int DEF_HOLD_CYCLES     = 255;
  localparam int DEF_STAGE_CYCLES    = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 1023;
endpackage

// File: rtl/button_debounce.sv
// Front-panel button synchronizer plus stable-count filter.
module button_debounce
  import rstseq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic button,
  output logic btn_db
);
  logic             sync1_q, button_s_q;
  logic             btn_db_q, btn_db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized level disagrees with btn_db.
  always_comb begin
    cnt_d    = '0;
    btn_db_d = btn_db_q;
    if (button_s_q != btn_db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) btn_db_d = button_s_q;
      else                                      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      button_s_q <= 1'b0;
      btn_db_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= button;
      button_s_q <= sync1_q;
      btn_db_q   <= btn_db_d;
      cnt_q      <= cnt_d;
    end
  end

  assign btn_db = btn_db_q;
endmodule

// File: rtl/reset_sequencer.sv
// Waits for clock lock, holds all domains in reset, then releases mem, vid, cpu in order.
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int STAGE_CYCLES    = DEF_STAGE_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic dcm_locked,
  input  logic button,
  output logic mem_reset,
  output logic vid_reset,
  output logic cpu_reset,
  output logic ready
);
  logic             locked_s1_q, locked_s_q;
  logic             btn_db;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .button  (button),
    .btn_db  (btn_db)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!locked_s_q) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end else if (btn_db && (state_q != WAIT_LOCK)) begin
      state_d = HOLD;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
        HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            state_d = MEM;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
        MEM: begin
          if (cnt_q == CNT_W'(STAGE_CYCLES - 1)) begin
            state_d = VID;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
        VID: begin
          if (cnt_q == CNT_W'(STAGE_CYCLES - 1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
        RUN:     cnt_d = '0;
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      locked_s1_q <= 1'b0;
      locked_s_q  <= 1'b0;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
    end else begin
      locked_s1_q <= dcm_locked;
      locked_s_q  <= locked_s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  // Decoded straight from the state register; any unexpected code reads as full reset.
  assign mem_reset = !((state_q == MEM) || (state_q == VID) || (state_q == RUN));
  assign vid_reset = !((state_q == VID) || (state_q == RUN));
  assign cpu_reset = (state_q != RUN);
  assign ready     = (state_q == RUN);
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed and randomized checks of reset_sequencer against a release-timeline model.
module tb_reset_sequencer;
  localparam int H = 8;
  localparam int S = 4;
  localparam int D = 16;

  logic sysclk = 1'b0;
  logic reset_n = 1'b1;
  logic dcm_locked = 1'b0;
  logic button = 1'b0;
  logic mem_reset, vid_reset, cpu_reset, ready;

  int checks = 0;
  int passes = 0;

  reset_sequencer #(
    .HOLD_CYCLES     (H),
    .STAGE_CYCLES    (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .dcm_locked (dcm_locked),
    .button     (button),
    .mem_reset  (mem_reset),
    .vid_reset  (vid_reset),
    .cpu_reset  (cpu_reset),
    .ready      (ready)
  );

  always #5 sysclk = ~sysclk;

  // Model: delayed copies of the inputs, a debounced level, and a single
  // "cycles since the hold interval started" timeline from which every
  // release point is derived.
  logic m_lk1, m_lk2, m_bs1, m_bs2, m_db, m_seq;
  int   m_dcnt, m_el;

  always @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      m_lk1 <= 1'b0; m_lk2 <= 1'b0; m_bs1 <= 1'b0; m_bs2 <= 1'b0;
      m_db <= 1'b0; m_seq <= 1'b0; m_dcnt <= 0; m_el <= 0;
    end else begin
      m_lk1 <= dcm_locked; m_lk2 <= m_lk1;
      m_bs1 <= button;     m_bs2 <= m_bs1;
      if (m_bs2 == m_db) m_dcnt <= 0;
      else if (m_dcnt + 1 == D) begin m_db <= m_bs2; m_dcnt <= 0; end
      else m_dcnt <= m_dcnt + 1;
      if (!m_lk2) begin m_seq <= 1'b0; m_el <= 0; end
      else if (!m_seq || m_db) begin m_seq <= 1'b1; m_el <= 0; end
      else if (m_el < H + 2 * S) m_el <= m_el + 1;
    end
  end

  logic [3:0] exp_v, act_v;
  assign exp_v = m_seq ? {m_el < H, m_el < H + S, m_el < H + 2 * S, m_el >= H + 2 * S}
                       : 4'b1110;
  assign act_v = {mem_reset, vid_reset, cpu_reset, ready};

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s at %0t: actual {mem,vid,cpu,ready}=%b required=%b", name, $time, act, req);
  endtask

  always @(negedge sysclk) check("cycle_model", act_v, exp_v);

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #2;
    end
  endtask

  initial begin
    int act, len;
    #1 reset_n = 1'b0;
    dcm_locked = 1'b1;
    #1 check("reset_state", act_v, 4'b1110);
    tick(3);
    reset_n = 1'b1;
    $display("power-up with lock present");
    tick(10); check("pu_edge10", act_v, 4'b1110);
    tick(1);  check("pu_edge11", act_v, 4'b0110);
    tick(3);  check("pu_edge14", act_v, 4'b0110);
    tick(1);  check("pu_edge15", act_v, 4'b0010);
    tick(3);  check("pu_edge18", act_v, 4'b0010);
    tick(1);  check("pu_edge19", act_v, 4'b0001);

    $display("lock loss in RUN");
    tick(5);
    dcm_locked = 1'b0;
    tick(1);
    dcm_locked = 1'b1;
    tick(1);  check("ll_edge2", act_v, 4'b0001);
    tick(1);  check("ll_edge3", act_v, 4'b1110);
    tick(16); check("ll_edge19", act_v, 4'b0010);
    tick(1);  check("ll_edge20", act_v, 4'b0001);

    $display("bounce in RUN");
    for (int i = 0; i < 12; i++) begin
      button = ~button;
      tick(5);
    end
    button = 1'b0;
    tick(30); check("bounce_run", act_v, 4'b0001);

    $display("held button during MEM");
    dcm_locked = 1'b0;
    tick(1);
    dcm_locked = 1'b1;
    tick(11); check("hb_in_mem", act_v, 4'b0110);
    button = 1'b1;
    tick(18); check("hb_press18", act_v, 4'b0001);
    tick(1);  check("hb_press19", act_v, 4'b1110);
    tick(21); check("hb_held40", act_v, 4'b1110);
    button = 1'b0;
    tick(25); check("hb_rel25", act_v, 4'b1110);
    tick(3);  check("hb_rel28", act_v, 4'b0110);

    $display("async reset mid-VID");
    tick(3);  check("ar_in_vid", act_v, 4'b0010);
    reset_n = 1'b0;
    #1 check("ar_immediate", act_v, 4'b1110);
    #4 reset_n = 1'b1;
    tick(10); check("ar_edge10", act_v, 4'b1110);
    tick(9);  check("ar_edge19", act_v, 4'b0001);

    $display("lock absent for 100 cycles");
    reset_n = 1'b0;
    dcm_locked = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(100); check("la_wait", act_v, 4'b1110);
    dcm_locked = 1'b1;
    tick(10); check("la_edge10", act_v, 4'b1110);
    tick(1);  check("la_edge11", act_v, 4'b0110);
    tick(7);  check("la_edge18", act_v, 4'b0010);
    tick(1);  check("la_edge19", act_v, 4'b0001);

    for (int ep = 0; ep < 60; ep++) begin
      act = $urandom_range(0, 4);
      case (act)
        0: begin
          len = $urandom_range(1, 4);
          dcm_locked = 1'b0; tick(len); dcm_locked = 1'b1;
        end
        1: begin
          len = $urandom_range(1, 40);
          button = 1'b1; tick(len); button = 1'b0;
        end
        2: begin
          len = $urandom_range(2, 10);
          for (int k = 0; k < len; k++) begin
            button = ~button; tick($urandom_range(1, D - 1));
          end
          button = 1'b0;
        end
        3: begin
          len = 0;
          @(negedge sysclk); #1 reset_n = 1'b0;
          #2 reset_n = 1'b1;
        end
        default: len = 0;
      endcase
      tick($urandom_range(5, 45));
      $display("episode %0d action %0d len %0d outputs %b", ep, act, len, act_v);
    end
    tick(40);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
